// File: rtl/id_ex_ctrl_reg.sv
// ID-stage main decoder feeding the ID/EX control pipeline register.
// Handles stall (hold), flush (bubble), sticky illegal-opcode flag and a saturating bubble count.
module id_ex_ctrl_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [2:0]       ex_aluop,
    output logic [5:0]       ex_func,
    output logic             ex_regwrite,
    output logic [1:0]       ex_regdst,
    output logic             ex_alusrc,
    output logic [1:0]       ex_extop,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_link,
    output logic [31:0]      ex_instr,
    output logic             illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_ORI   = 6'b001101,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_JR   = 6'b001000,
        FN_ADDU = 6'b100001,
        FN_SUBU = 6'b100011
    } func_e;

    logic       dec_illegal;
    logic [2:0] dec_aluop;
    logic [5:0] dec_func;
    logic       dec_regwrite;
    logic [1:0] dec_regdst;
    logic       dec_alusrc;
    logic [1:0] dec_extop;
    logic       dec_memwrite;
    logic       dec_memtoreg;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_link;

    always_comb begin
        dec_illegal  = 1'b0;
        dec_aluop    = 3'b111;
        dec_func     = '0;
        dec_regwrite = 1'b0;
        dec_regdst   = 2'b00;
        dec_alusrc   = 1'b0;
        dec_extop    = 2'b00;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_link     = 1'b0;
        case (id_instr[31:26])
            OP_RTYPE: begin
                dec_aluop = 3'b010;
                dec_func  = id_instr[5:0];
                case (id_instr[5:0])
                    FN_ADDU, FN_SUBU: begin
                        dec_regwrite = 1'b1;
                        dec_regdst   = 2'b01;
                    end
                    FN_JR:   dec_jump = 1'b1;
                    // only the all-zero word (nop) is legal with func 000000
                    default: dec_illegal = (id_instr != '0);
                endcase
            end
            OP_ORI, OP_LUI: begin
                dec_aluop    = 3'b011;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_extop    = (id_instr[31:26] == OP_LUI) ? 2'b10 : 2'b00;
            end
            OP_LW: begin
                dec_aluop    = 3'b000;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_extop    = 2'b01;
                dec_memtoreg = 1'b1;
            end
            OP_SW: begin
                dec_aluop    = 3'b000;
                dec_alusrc   = 1'b1;
                dec_extop    = 2'b01;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_aluop  = 3'b001;
                dec_branch = 1'b1;
                dec_extop  = 2'b01;
            end
            OP_JAL: begin
                dec_aluop    = 3'b111;
                dec_regwrite = 1'b1;
                dec_regdst   = 2'b10;
                dec_jump     = 1'b1;
                dec_link     = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic load_bubble;
    logic take_illegal;

    // an illegal word only counts when it would otherwise have been loaded
    assign take_illegal = !flush && !stall && id_valid && dec_illegal;
    assign load_bubble  = flush || (!stall && (!id_valid || dec_illegal));

    always_ff @(posedge clk) begin
        if (reset || load_bubble) begin
            ex_valid    <= 1'b0;
            ex_aluop    <= 3'b111;
            ex_func     <= '0;
            ex_regwrite <= 1'b0;
            ex_regdst   <= 2'b00;
            ex_alusrc   <= 1'b0;
            ex_extop    <= 2'b00;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_link     <= 1'b0;
            ex_instr    <= '0;
        end else if (!stall) begin
            ex_valid    <= 1'b1;
            ex_aluop    <= dec_aluop;
            ex_func     <= dec_func;
            ex_regwrite <= dec_regwrite;
            ex_regdst   <= dec_regdst;
            ex_alusrc   <= dec_alusrc;
            ex_extop    <= dec_extop;
            ex_memwrite <= dec_memwrite;
            ex_memtoreg <= dec_memtoreg;
            ex_branch   <= dec_branch;
            ex_jump     <= dec_jump;
            ex_link     <= dec_link;
            ex_instr    <= id_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal    <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            if (take_illegal)
                illegal <= 1'b1;
            if (load_bubble && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_ex_ctrl_reg.md
Name: id_ex_ctrl_reg

Overview:
- ID-stage main decoder plus ID/EX control pipeline register.
- Decodes the 32-bit instruction in ID into the 3-bit aluop / 6-bit func pair consumed by the EX-stage ALU control decoder, together with the remaining datapath control bits.
- Registers all outputs into EX with stall (hold) and flush (bubble) handling.
- Flags illegal opcodes and counts inserted bubbles.

Parameters:
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_instr  in  32  instruction currently in ID
- id_valid  in  1  id_instr holds a real instruction
- stall  in  1  hold ID/EX contents this cycle
- flush  in  1  load a bubble into ID/EX this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_aluop  out  3  000 add, 001 sub, 010 R-type (use func), 011 or, 111 zero
- ex_func  out  6  instr[5:0] for R-type, else 0
- ex_regwrite  out  1  write register file
- ex_regdst  out  2  00 rt, 01 rd, 10 $31
- ex_alusrc  out  1  ALU B operand is the extended immediate
- ex_extop  out  2  00 zero-extend, 01 sign-extend, 10 load-upper
- ex_memwrite  out  1  data memory write
- ex_memtoreg  out  1  write-back from memory
- ex_branch  out  1  beq
- ex_jump  out  1  jal or jr
- ex_link  out  1  jal
- ex_instr  out  32  instruction held in EX (0 for a bubble)
- illegal  out  1  sticky: an undecodable instruction was accepted
- bubble_cnt  out  CNT_W  number of bubbles loaded, saturating

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Bubble value: ex_valid=0, ex_aluop=111, ex_instr=0, all other control outputs 0.
- Reset: all outputs take the bubble value; illegal=0; bubble_cnt=0. Reset applied mid-stream discards EX contents the same cycle. Reset does not increment bubble_cnt.
- Priority each edge: reset > flush > stall > load.
  - flush: bubble loaded. flush wins over a simultaneous stall.
  - stall alone: every ex_* output holds its value.
  - Otherwise: if id_valid=1, load the decoded instruction; if id_valid=0, load a bubble.
- Latency: decode is combinational from id_instr; its outputs are visible on ex_* exactly 1 cycle after the load edge.
- Decode by opcode instr[31:26] (unlisted control bits are 0):
  - 000000 R-type, aluop 010, ex_func = instr[5:0]:
    - func 100001 (addu) or 100011 (subu): regwrite=1, regdst=01.
    - func 001000 (jr): jump=1, regwrite=0.
    - instr == 0 (nop): all control bits 0, ex_valid=1, not illegal.
    - Any other func: illegal.
  - 001101 ori: aluop 011, regwrite=1, regdst=00, alusrc=1, extop=00.
  - 001111 lui: aluop 011, regwrite=1, regdst=00, alusrc=1, extop=10.
  - 100011 lw: aluop 000, regwrite=1, regdst=00, alusrc=1, extop=01, memtoreg=1.
  - 101011 sw: aluop 000, alusrc=1, extop=01, memwrite=1.
  - 000100 beq: aluop 001, branch=1, extop=01.
  - 000011 jal: aluop 111, regwrite=1, regdst=10, jump=1, link=1.
- Illegal instruction:
  - An illegal instruction with id_valid=1, loaded with no reset, flush or stall, loads a bubble and sets illegal=1.
  - illegal stays 1 until reset.
  - An illegal instruction that is stalled or flushed does not set the flag.
- bubble_cnt:
  - Increments by 1 on every edge that loads a bubble: flush, id_valid=0, or an illegal load.
  - Holds on stall.
  - Saturates at 2^CNT_W-1; no wrap.
- ex_func is forced to 0 for every non-R-type opcode, regardless of instr[5:0].

Test Plan:
- Reset held 2 cycles, then released -> ex_valid=0, ex_aluop=111, ex_instr=0, bubble_cnt=0, illegal=0.
- Load addu $3,$1,$2 (0x00221821) with id_valid=1 -> next cycle ex_aluop=010, ex_func=100001, regwrite=1, regdst=01, ex_valid=1. Repeat with lw 0x8C220004 -> aluop=000, alusrc=1, extop=01, memtoreg=1.
- Load sw, then assert stall for 3 cycles with beq on id_instr -> outputs hold the sw decode (memwrite=1) for 3 cycles; beq (aluop=001, branch=1) appears 1 cycle after stall drops.
- stall=1 and flush=1 together while jal is loaded -> bubble loaded, bubble_cnt += 1. Next cycle, jal with no stall or flush -> aluop=111, regdst=10, link=1.
- id_instr = 0xFC000000 (opcode 111111) with id_valid=1 -> bubble loaded, illegal=1, bubble_cnt += 1. illegal stays 1 across later legal loads and clears only on reset.
- CNT_W=2 with 5 consecutive flushes -> bubble_cnt reads 1,2,3,3,3. Reset mid-sequence -> bubble_cnt=0 and outputs show the bubble value on the next cycle.
